// File: rtl/add_pipe_nbit.sv
// rtl/add_pipe_nbit.sv - chunked pipelined adder/subtractor; optional saturation via ADD_PIPE_SAT_EN
module add_pipe_nbit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ADD_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C = WIDTH / STAGES;

  logic             w_adv;
  logic             w_acc;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic             w_sat;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  // Global stall: the whole pipe freezes only while a finished result waits.
  assign w_adv     = !(r_out_valid && !out_ready);
  assign in_ready  = w_adv;
  assign w_acc     = in_valid && w_adv;

  // Subtraction folds into addition: a + ~b + ~cin.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = cin ^ sub;

`ifdef ADD_PIPE_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic               w_vld_in;
    logic               w_cy_in;
    logic               w_sat_in;
    logic [C-1:0]       w_a_ch;
    logic [C-1:0]       w_b_ch;
    logic [C:0]         w_ch;
    logic [(k+1)*C-1:0] w_sum_nxt;

    // Stage 0 eats the raw beat; later stages eat the skewed operands of the previous stage.
    if (k == 0) begin : g_src
      assign w_vld_in  = w_acc;
      assign w_cy_in   = w_cin_eff;
      assign w_sat_in  = w_sat;
      assign w_a_ch    = a[C-1:0];
      assign w_b_ch    = w_b_eff[C-1:0];
      assign w_sum_nxt = w_ch[C-1:0];
    end else begin : g_src
      assign w_vld_in  = g_stg[k-1].g_fwd.r_vld;
      assign w_cy_in   = g_stg[k-1].g_fwd.r_cy;
      assign w_sat_in  = g_stg[k-1].g_fwd.r_sat;
      assign w_a_ch    = g_stg[k-1].g_fwd.r_a[C-1:0];
      assign w_b_ch    = g_stg[k-1].g_fwd.r_b[C-1:0];
      assign w_sum_nxt = {w_ch[C-1:0], g_stg[k-1].g_fwd.r_sum};
    end

    assign w_ch = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{C{1'b0}}, w_cy_in};

    if (k < STAGES - 1) begin : g_fwd
      localparam int RW = WIDTH - (k + 1) * C;

      logic               r_vld;
      logic               r_cy;
      logic               r_sat;
      logic [RW-1:0]      r_a;
      logic [RW-1:0]      r_b;
      logic [(k+1)*C-1:0] r_sum;
      logic [RW-1:0]      w_a_up;
      logic [RW-1:0]      w_b_up;

      // Only the not-yet-added operand chunks travel further down the pipe.
      if (k == 0) begin : g_up
        assign w_a_up = a[WIDTH-1:C];
        assign w_b_up = w_b_eff[WIDTH-1:C];
      end else begin : g_up
        assign w_a_up = g_stg[k-1].g_fwd.r_a[RW+C-1:C];
        assign w_b_up = g_stg[k-1].g_fwd.r_b[RW+C-1:C];
      end

      // Intermediate stage register: shifts on advance, data only loads under a valid beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld <= 1'b0;
          r_cy  <= 1'b0;
          r_sat <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
          r_sum <= '0;
        end else if (w_adv) begin
          r_vld <= w_vld_in;
          if (w_vld_in) begin
            r_cy  <= w_ch[C];
            r_sat <= w_sat_in;
            r_a   <= w_a_up;
            r_b   <= w_b_up;
            r_sum <= w_sum_nxt;
          end
        end
      end
    end else begin : g_last
      logic             w_ovf;
      logic [WIDTH-1:0] w_res;

      // Carry into the MSB is recovered as a^b^sum at that bit.
      assign w_ovf = w_a_ch[C-1] ^ w_b_ch[C-1] ^ w_ch[C-1] ^ w_ch[C];

      // Clamp direction follows the operand sign: both operands share it when overflow occurs.
      always_comb begin
        w_res = w_sum_nxt;
        if (w_sat_in && w_ovf) begin
          w_res = w_a_ch[C-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end

      // Output stage register: results and flags hold while stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_valid <= 1'b0;
          r_s         <= '0;
          r_cout      <= 1'b0;
          r_ovf       <= 1'b0;
          r_zero      <= 1'b0;
        end else if (w_adv) begin
          r_out_valid <= w_vld_in;
          if (w_vld_in) begin
            r_s    <= w_res;
            r_cout <= w_ch[C];
            r_ovf  <= w_ovf;
            r_zero <= (w_res == '0);
          end
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_add_pipe_nbit.sv
// tb/tb_add_pipe_nbit.sv - bench for add_pipe_nbit (WIDTH=16, STAGES=4)
module tb_add_pipe_nbit;

`ifdef ADD_PIPE_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        sat_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;

  add_pipe_nbit #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef ADD_PIPE_SAT_EN
    .sat       (sat_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
    bit          stalled;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  logic [15:0] last_s;
  logic        last_cout, last_ovf, last_zero;
  logic        p_hold = 1'b0;
  logic [15:0] p_s;
  logic        p_c, p_o, p_z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: exact integer sums, unsigned for carry, signed for overflow.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic msub, input logic msat);
    exp_t e;
    int   u, sx;
    if (msub) begin
      u       = int'(ma) - int'(mb) - int'(mc);
      sx      = int'($signed(ma)) - int'($signed(mb)) - int'(mc);
      e.cout  = (u >= 0);
    end else begin
      u       = int'(ma) + int'(mb) + int'(mc);
      sx      = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
      e.cout  = (u > 65535);
    end
    e.s   = u[15:0];
    e.ovf = (sx > 32767) || (sx < -32768);
    if (msat && e.ovf) e.s = (sx > 0) ? 16'h7fff : 16'h8000;
    e.zero    = (e.s == 16'h0000);
    e.acc     = 0;
    e.stalled = 1'b0;
    return e;
  endfunction

  // One clock: drive after negedge, sample 1ns later, score outputs and acceptance.
  task automatic cycle(input logic v, input logic [15:0] ta, input logic [15:0] tb2,
                       input logic tc, input logic tsub, input logic tsat,
                       input logic tordy, input logic trst, output logic acc);
    exp_t e;
    @(negedge clk);
    rst = trst; in_valid = v; a = ta; b = tb2; cin = tc; sub = tsub; sat_i = tsat;
    out_ready = tordy;
    #1;
    acc = 1'b0;
    if (trst) begin
      q.delete();
      p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_s", {16'd0, s}, {16'd0, p_s});
        check("hold_flags", {29'd0, cout, ovf, zero}, {29'd0, p_c, p_o, p_z});
      end
      check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else if (out_ready) begin
          e = q.pop_front();
          check("res_s", {16'd0, s}, {16'd0, e.s});
          check("res_flags", {29'd0, cout, ovf, zero}, {29'd0, e.cout, e.ovf, e.zero});
          if (!e.stalled) check("latency", cyc - e.acc, 32'd4);
          last_s = s; last_cout = cout; last_ovf = ovf; last_zero = zero;
          pops++;
        end
      end
      if (out_valid && !out_ready) begin
        foreach (q[i]) q[i].stalled = 1'b1;
      end
      p_hold = out_valid && !out_ready;
      p_s = s; p_c = cout; p_o = ovf; p_z = zero;
      if (v && in_ready) begin
        e = model(ta, tb2, tc, tsub, tsat && SAT_ON);
        e.acc = cyc;
        q.push_back(e);
        acc = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input logic tordy);
    logic acc;
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, tordy, 1'b0, acc);
  endtask

  task automatic single(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                        input logic tsub, input logic tsat, input logic [15:0] es,
                        input logic ec, input logic eo, input logic ez);
    logic acc;
    int   p0;
    p0 = pops;
    cycle(1'b1, ta, tb2, tc, tsub, tsat, 1'b1, 1'b0, acc);
    check("single_accept", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 12 && pops == p0; i++) idle(1'b1);
    check("single_done", pops - p0, 32'd1);
    check("vec_s", {16'd0, last_s}, {16'd0, es});
    check("vec_flags", {29'd0, last_cout, last_ovf, last_zero}, {29'd0, ec, eo, ez});
  endtask

  initial begin
    logic acc;
    int   n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat_i = 1'b0;
    out_ready = 1'b1;

    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    idle(1'b1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    single(16'h1234, 16'h0fff, 1'b0, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    single(16'hffff, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    single(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7fff, 1'b1, 1'b1, 1'b0);
    single(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 16'hfffe, 1'b0, 1'b0, 1'b0);
    single(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    single(16'h7fff, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    single(16'h7fff, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
`ifdef ADD_PIPE_SAT_EN
    single(16'h7fff, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7fff, 1'b0, 1'b1, 1'b0);
    single(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`endif

    // Backpressure: 8 beats back to back, consumer stalls in cycles 5..7.
    n = 0;
    begin
      int p0;
      p0 = pops;
      for (int c = 0; c < 40 && (n < 8 || q.size() != 0); c++) begin
        cycle(n < 8, 16'(n), 16'(n * 256), 1'b0, 1'b0, 1'b0, !(c >= 5 && c <= 7), 1'b0, acc);
        if (c >= 5 && c <= 7) check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        if (acc) n++;
      end
      check("bp_all_out", pops - p0, 32'd8);
    end

    // Reset mid-flight: three beats in the pipe, then a reset cycle with a beat offered.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i + 5), 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b1, 16'h4444, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    idle(1'b1);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      idle(1'b1);
    end
    single(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0, 1'b0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom % 4) != 0, 1'b0, acc);
    end
    for (int i = 0; i < 30 && q.size() != 0; i++) idle(1'b1);
    check("drain_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
